mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single shared memory port between the instruction-fetch path and the load/store data path of the multi-cycle RISC-V core. The block runs a per-transaction request/acknowledge handshake with each requester and a request/ready handshake with memory. It registers the winning request's address, data and strobes, and returns read data with a one-cycle acknowledge pulse. A watchdog aborts transactions that memory never completes, so the core FSM cannot hang.

## Interface
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- TIMEOUT, 16, max BUSY cycles awaiting mem_ready; legal range 2..255
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low; clock clk
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DW  fetched word, valid while if_ack=1
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  byte enables (stores only)
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  load data, valid while d_ack=1
- err  out  1  with an ack: transaction timed out
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_be  out  DW/8  memory byte enables; all ones on reads
- mem_ready  in  1  memory completion; read data is valid on mem_rdata in the same cycle
- mem_rdata  in  DW  memory read data

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, ACK.
- IDLE
  - If either request is high, pick a winner per arbitration.
  - Latch the winner's addr, we, wdata and be into the mem_* registers; clear the watchdog counter.
  - Go to BUSY_I or BUSY_D. With no request, stay in IDLE.
- BUSY_x
  - mem_req=1; mem_* outputs hold the latched values and do not track requester inputs.
  - mem_ready=1: capture mem_rdata into the owner's rdata register (loads and fetches only), err<=0, go to ACK.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without mem_ready: rdata<=0, err<=1, go to ACK.
- ACK
  - The owner's ack=1 and the other ack=0; mem_req=0. Requests are ignored in this state.
  - Next state is IDLE.
  - The owner drops its req, or presents a new request, in the cycle after ack.
- Arbitration (default build): fixed priority, d_req beats if_req.
- Stores leave d_rdata unchanged; d_ack is still pulsed.
- err is valid only while an ack is high; it is cleared on the next grant.
- Reset values: state IDLE; mem_req, mem_we, if_ack, d_ack and err all 0; mem_addr, mem_wdata, mem_be, if_rdata and d_rdata all 0; last-grant flag = fetch.
- Reset asserted in any state: the transaction is abandoned at that edge, with no ack and no err. mem_req is 0 from the next cycle.
- A request that drops before its grant is simply not served.

## Timing
- A request sampled in IDLE at edge N makes mem_req=1 in cycle N+1.
- mem_ready=1 in cycle N+1 makes ack=1 in cycle N+2. Minimum latency is therefore 2 cycles from request sample to ack.
- Each cycle of memory wait adds 1 cycle of latency.
- Maximum throughput is one transaction per 3 cycles (IDLE, BUSY, ACK).
- Timeout: the ack arrives TIMEOUT+1 cycles after the grant edge.
- Requests that are simultaneous in IDLE resolve in the same cycle; the loser stays pending and is evaluated at the next IDLE.
- mem_ready outside the BUSY states is ignored.

## Configuration
- MEM_PORT_ARB_RR_EN defined
  - Round-robin arbitration: with both requests high in IDLE, grant the requester not granted last.
  - The last-grant flag updates on every grant; its reset value is fetch, so the first tie goes to data.
  - A single requester is always granted.
- Undefined: fixed data-over-fetch priority; the last-grant flag is not implemented.

## Test plan
- Fetch with immediate ready
  - Stimulus: if_req=1, if_addr=0x100; mem_ready=1 in the first BUSY cycle with mem_rdata=0x00500093.
  - Required: mem_addr=0x100 and mem_we=0 in cycle 1; if_ack=1 with if_rdata=0x00500093 and err=0 in cycle 2.
- Store with wait states
  - Stimulus: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=0b0011; mem_ready is delayed 3 cycles.
  - Required: mem_* hold these values for 4 BUSY cycles; d_ack pulses once; d_rdata is unchanged.
- Simultaneous requests, default build
  - Stimulus: if_req and d_req rise together.
  - Required: data is served first; fetch is granted in the IDLE after d_ack; fetch mem_req appears 3 cycles after data mem_req when memory is zero-wait.
- Simultaneous requests, MEM_PORT_ARB_RR_EN
  - Stimulus: both requests held continuously for 4 transactions.
  - Required: grant order is D, I, D, I.
- Timeout and reset
  - Stimulus (TIMEOUT=4): d_req load with mem_ready tied 0.
  - Required: d_ack=1, err=1, d_rdata=0 exactly 5 cycles after the grant edge.
  - Stimulus: a separate run asserts rst=0 during BUSY_I.
  - Required: no if_ack; mem_req=0 and all outputs at reset values after the edge.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Shared-memory-port bundle: fetch and load/store requesters plus the memory side.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_ack;
    logic [DW-1:0]   if_rdata;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic            d_ack;
    logic [DW-1:0]   d_rdata;
    logic            err;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for one shared memory port, with a BUSY watchdog.
// Define MEM_PORT_ARB_RR_EN for round-robin ties instead of data-over-fetch priority.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ACK} state_e;

    state_e            state_q, state_d;
    logic              grant_i, grant_d, busy, tmo;
    logic [7:0]        cnt_q;
    logic              mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DW-1:0]     mem_wdata_q;
    logic [DW/8-1:0]   mem_be_q;
    logic [DW-1:0]     if_rdata_q, d_rdata_q;
    logic              if_ack_q, d_ack_q, err_q;
`ifdef MEM_PORT_ARB_RR_EN
    logic              last_d_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:           if (grant_d) state_d = BUSY_D;
                            else if (grant_i) state_d = BUSY_I;
            BUSY_I, BUSY_D: if (bus.mem_ready || tmo) state_d = ACK;
            ACK:            state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
        tmo     = busy && !bus.mem_ready && (cnt_q == 8'(TIMEOUT - 1));
        if (state_q == IDLE) begin
`ifdef MEM_PORT_ARB_RR_EN
            if (bus.d_req && bus.if_req) begin
                grant_d = !last_d_q;
                grant_i = last_d_q;
            end else begin
                grant_d = bus.d_req;
                grant_i = bus.if_req;
            end
`else
            grant_d = bus.d_req;
            grant_i = bus.if_req && !bus.d_req;
`endif
        end
    end

    // Acks are registered on the BUSY->ACK transition, so they coincide with the ACK state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            if (grant_i || grant_d) begin
                mem_we_q    <= grant_d && bus.d_we;
                mem_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
                mem_wdata_q <= grant_d ? bus.d_wdata : '0;
                mem_be_q    <= (grant_d && bus.d_we) ? bus.d_be : '1;
                cnt_q       <= '0;
                err_q       <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
                last_d_q    <= grant_d;
`endif
            end else if (busy) begin
                if (bus.mem_ready || tmo) begin
                    err_q <= tmo;
                    if (state_q == BUSY_I) begin
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= tmo ? '0 : bus.mem_rdata;
                    end else begin
                        d_ack_q <= 1'b1;
                        if (tmo)            d_rdata_q <= '0;
                        else if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
                    end
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.mem_req   = busy;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4); tie test follows MEM_PORT_ARB_RR_EN.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        rst = 0;
        tick(); tick();
        check_eq("rst_mem_req", bus.mem_req, 0);
        check_eq("rst_mem_we", bus.mem_we, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_be", bus.mem_be, 0);
        check_eq("rst_if_ack", bus.if_ack, 0);
        check_eq("rst_d_ack", bus.d_ack, 0);
        check_eq("rst_err", bus.err, 0);
        rst = 1;
        bus.mem_ready = 1;
        tick();
        check_eq("idle_ready_ignored", bus.if_ack | bus.d_ack, 0);
        bus.mem_ready = 0;

        // Fetch, zero wait
        bus.if_req = 1; bus.if_addr = 32'h100;
        tick();
        check_eq("f_mem_req", bus.mem_req, 1);
        check_eq("f_mem_addr", bus.mem_addr, 32'h100);
        check_eq("f_mem_we", bus.mem_we, 0);
        check_eq("f_mem_be", bus.mem_be, 4'hF);
        bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
        tick();
        check_eq("f_if_ack", bus.if_ack, 1);
        check_eq("f_if_rdata", bus.if_rdata, 32'h00500093);
        check_eq("f_err", bus.err, 0);
        check_eq("f_d_ack", bus.d_ack, 0);
        check_eq("f_ack_mem_req", bus.mem_req, 0);
        bus.if_req = 0; bus.mem_ready = 0;
        tick();
        check_eq("f_ack_pulse", bus.if_ack, 0);

        // Load, zero wait
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000; bus.d_wdata = 32'h55; bus.d_be = 4'h0;
        tick();
        check_eq("ld_mem_be", bus.mem_be, 4'hF);
        check_eq("ld_mem_we", bus.mem_we, 0);
        check_eq("ld_mem_addr", bus.mem_addr, 32'h3000);
        bus.mem_ready = 1; bus.mem_rdata = 32'h12345678;
        tick();
        check_eq("ld_d_ack", bus.d_ack, 1);
        check_eq("ld_d_rdata", bus.d_rdata, 32'h12345678);
        check_eq("ld_if_ack", bus.if_ack, 0);
        bus.d_req = 0; bus.mem_ready = 0;
        tick();

        // Store, 3 wait states; requester inputs wander after grant
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'b0011;
        tick();
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = 4'hC;
        for (int i = 0; i < 4; i++) begin
            check_eq("st_mem_req", bus.mem_req, 1);
            check_eq("st_mem_we", bus.mem_we, 1);
            check_eq("st_mem_addr", bus.mem_addr, 32'h2004);
            check_eq("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
            check_eq("st_mem_be", bus.mem_be, 4'b0011);
            check_eq("st_no_ack", bus.d_ack, 0);
            if (i == 3) begin
                bus.mem_ready = 1; bus.mem_rdata = 32'hBADBAD00;
            end
            tick();
        end
        check_eq("st_d_ack", bus.d_ack, 1);
        check_eq("st_d_rdata_kept", bus.d_rdata, 32'h12345678);
        check_eq("st_err", bus.err, 0);
        bus.d_req = 0; bus.d_we = 0; bus.mem_ready = 0;
        tick();
        check_eq("st_ack_pulse", bus.d_ack, 0);

        // Load timeout: ack TIMEOUT+1 = 5 cycles after the grant edge
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h40;
        tick();
        for (int i = 1; i <= 4; i++) begin
            check_eq("to_busy", bus.mem_req, 1);
            check_eq("to_no_ack", bus.d_ack, 0);
            tick();
        end
        check_eq("to_d_ack", bus.d_ack, 1);
        check_eq("to_err", bus.err, 1);
        check_eq("to_d_rdata", bus.d_rdata, 0);
        check_eq("to_mem_req", bus.mem_req, 0);
        bus.d_req = 0;
        tick();

        // Reset during BUSY_I
        bus.if_req = 1; bus.if_addr = 32'h200;
        tick();
        check_eq("rb_mem_req", bus.mem_req, 1);
        rst = 0;
        tick();
        check_eq("rb_mem_req_off", bus.mem_req, 0);
        check_eq("rb_if_ack", bus.if_ack, 0);
        check_eq("rb_mem_addr", bus.mem_addr, 0);
        check_eq("rb_mem_be", bus.mem_be, 0);
        check_eq("rb_if_rdata", bus.if_rdata, 0);
        check_eq("rb_err", bus.err, 0);
        bus.if_req = 0;
        tick();
        rst = 1;
        tick();
        check_eq("rb_no_late_ack", bus.if_ack, 0);

        // Simultaneous requests
        bus.if_addr = 32'h500; bus.d_addr = 32'h600; bus.d_we = 0;
        bus.if_req = 1; bus.d_req = 1;
`ifdef MEM_PORT_ARB_RR_EN
        for (int t = 0; t < 4; t++) begin
            tick();
            check_eq("rr_mem_addr", bus.mem_addr, (t % 2 == 0) ? 32'h600 : 32'h500);
            bus.mem_ready = 1;
            tick();
            check_eq("rr_d_ack", bus.d_ack, (t % 2 == 0) ? 1 : 0);
            check_eq("rr_if_ack", bus.if_ack, (t % 2 == 0) ? 0 : 1);
            bus.mem_ready = 0;
            tick();
        end
`else
        tick();
        check_eq("pri_d_mem_req", bus.mem_req, 1);
        check_eq("pri_d_addr", bus.mem_addr, 32'h600);
        bus.mem_ready = 1;
        tick();
        check_eq("pri_d_ack", bus.d_ack, 1);
        check_eq("pri_if_wait", bus.if_ack, 0);
        bus.d_req = 0; bus.mem_ready = 0;
        tick();
        check_eq("pri_idle_gap", bus.mem_req, 0);
        tick();
        check_eq("pri_i_mem_req", bus.mem_req, 1);
        check_eq("pri_i_addr", bus.mem_addr, 32'h500);
        bus.mem_ready = 1;
        tick();
        check_eq("pri_if_ack", bus.if_ack, 1);
        bus.mem_ready = 0;
`endif
        bus.if_req = 0; bus.d_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
